// File: rtl/sram_1p_arbiter.sv
// Two-requester round-robin arbiter and sequencer for a single-port SRAM.
// Commands are granted combinationally, SRAM pins and responses are registered.
module sram_1p_arbiter #(
    parameter int unsigned WWORD = 32,
    parameter int unsigned WADDR = 5,
    parameter int unsigned DEPTH = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WADDR-1:0] addr0,
    input  logic [WADDR-1:0] addr1,
    input  logic [WWORD-1:0] wdata0,
    input  logic [WWORD-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic             err0,
    output logic             err1,
    output logic [WWORD-1:0] rdata,
    output logic             sram_cen,
    output logic             sram_wen,
    output logic [WADDR-1:0] sram_a,
    output logic [WWORD-1:0] sram_d,
    input  logic [WWORD-1:0] sram_q
);

    // Priority pointer and first read-return stage
    logic             last;
    logic             s1_valid;
    logic             s1_id;

    // Selected command
    logic             accept;
    logic             cmd_we;
    logic [WADDR-1:0] cmd_addr;
    logic [WWORD-1:0] cmd_wdata;
    logic             in_range;

    // Next-state values
    logic             last_n;
    logic             s1_valid_n;
    logic             s1_id_n;
    logic             rvalid0_n;
    logic             rvalid1_n;
    logic             err0_n;
    logic             err1_n;
    logic             cen_n;
    logic             wen_n;
    logic [WADDR-1:0] a_n;
    logic [WWORD-1:0] d_n;

    // Round-robin grant: the requester that was not granted last wins a tie
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rstn) begin
            if (req0 && (!req1 || last)) begin
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end
        end
    end

    assign accept    = gnt0 | gnt1;
    assign cmd_we    = gnt1 ? we1    : we0;
    assign cmd_addr  = gnt1 ? addr1  : addr0;
    assign cmd_wdata = gnt1 ? wdata1 : wdata0;
    assign in_range  = (32'(cmd_addr) < DEPTH);
    assign rdata     = sram_q;

    // Next-state: SRAM pins, error strobes and read-return pipeline
    always_comb begin
        last_n     = last;
        s1_valid_n = 1'b0;
        s1_id_n    = s1_id;
        rvalid0_n  = s1_valid & ~s1_id;
        rvalid1_n  = s1_valid &  s1_id;
        err0_n     = 1'b0;
        err1_n     = 1'b0;
        cen_n      = 1'b1;
        wen_n      = 1'b1;
        a_n        = sram_a;
        d_n        = sram_d;
        if (accept) begin
            last_n = gnt1;
            if (in_range) begin
                a_n = cmd_addr;
                if (cmd_we) begin
                    wen_n = 1'b0;
                    d_n   = cmd_wdata;
                end else begin
                    cen_n      = 1'b0;
                    s1_valid_n = 1'b1;
                    s1_id_n    = gnt1;
                end
            end else begin
                // Rejected command never reaches the SRAM
                err0_n = gnt0;
                err1_n = gnt1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            last     <= 1'b1;
            s1_valid <= 1'b0;
            s1_id    <= 1'b0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            err0     <= 1'b0;
            err1     <= 1'b0;
            sram_cen <= 1'b1;
            sram_wen <= 1'b1;
            sram_a   <= '0;
            sram_d   <= '0;
        end else begin
            last     <= last_n;
            s1_valid <= s1_valid_n;
            s1_id    <= s1_id_n;
            rvalid0  <= rvalid0_n;
            rvalid1  <= rvalid1_n;
            err0     <= err0_n;
            err1     <= err1_n;
            sram_cen <= cen_n;
            sram_wen <= wen_n;
            sram_a   <= a_n;
            sram_d   <= d_n;
        end
    end

endmodule

// File: tb/tb_sram_1p_arbiter.sv
// Directed bench for sram_1p_arbiter with a behavioural single-port SRAM model.
module tb_sram_1p_arbiter;

    localparam int unsigned WWORD = 32;
    localparam int unsigned WADDR = 5;
    localparam int unsigned DEPTH = 24;

    logic             clk;
    logic             rstn;
    logic             req0, req1, we0, we1;
    logic [WADDR-1:0] addr0, addr1;
    logic [WWORD-1:0] wdata0, wdata1;
    logic             gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [WWORD-1:0] rdata;
    logic             sram_cen, sram_wen;
    logic [WADDR-1:0] sram_a;
    logic [WWORD-1:0] sram_d;
    logic [WWORD-1:0] sram_q;

    logic [WWORD-1:0] mem [0:DEPTH-1];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [WWORD-1:0] DATA_A = 32'hA1A1_0001;
    localparam logic [WWORD-1:0] DATA_B = 32'hB2B2_0002;

    sram_1p_arbiter #(.WWORD(WWORD), .WADDR(WADDR), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .err0(err0), .err1(err1), .rdata(rdata),
        .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_a(sram_a),
        .sram_d(sram_d), .sram_q(sram_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM: registered read, out-of-range writes dropped
    initial sram_q = '0;
    always @(posedge clk) begin
        if (!sram_cen && 32'(sram_a) < DEPTH) sram_q <= mem[sram_a];
        if (!sram_wen && 32'(sram_a) < DEPTH) mem[sram_a] <= sram_d;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic exp_g0;
        logic exp_v0;

        rstn = 1'b0;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset values with both requests held
        step(); step(); step();
        #1;
        check("rst_gnt0", 32'(gnt0), 32'd0);
        check("rst_gnt1", 32'(gnt1), 32'd0);
        check("rst_cen", 32'(sram_cen), 32'd1);
        check("rst_wen", 32'(sram_wen), 32'd1);
        check("rst_a", 32'(sram_a), 32'd0);
        check("rst_rv", 32'({rvalid1, rvalid0, err1, err0}), 32'd0);
        rstn = 1'b1; req0 = 1'b0; req1 = 1'b0;
        step();

        // Single write then read from requester 0
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
        #1;
        check("wr_gnt0", 32'(gnt0), 32'd1);
        check("wr_gnt1", 32'(gnt1), 32'd0);
        step();
        we0 = 1'b0;
        #1;
        check("wr_wen", 32'(sram_wen), 32'd0);
        check("wr_cen", 32'(sram_cen), 32'd1);
        check("wr_a", 32'(sram_a), 32'd5);
        check("wr_d", sram_d, 32'hDEAD_BEEF);
        check("rd_gnt0", 32'(gnt0), 32'd1);
        step();
        req0 = 1'b0;
        #1;
        check("rd_cen", 32'(sram_cen), 32'd0);
        check("rd_wen", 32'(sram_wen), 32'd1);
        step();
        check("rd_rvalid0", 32'(rvalid0), 32'd1);
        check("rd_rvalid1", 32'(rvalid1), 32'd0);
        check("rd_rdata", rdata, 32'hDEAD_BEEF);

        // Preload addr 1 via requester 0 and addr 2 via requester 1
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd1; wdata0 = DATA_A;
        #1;
        check("pre_gnt0", 32'(gnt0), 32'd1);
        step();
        req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 5'd2; wdata1 = DATA_B;
        #1;
        check("pre_gnt1", 32'(gnt1), 32'd1);
        step();

        // Continuous contention: alternate grants starting with requester 0
        req0 = 1'b1; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (k == 8) begin
                req0 = 1'b0; req1 = 1'b0;
            end
            #1;
            if (k < 8) begin
                exp_g0 = (k % 2 == 0);
                check("cont_gnt0", 32'(gnt0), 32'(exp_g0));
                check("cont_gnt1", 32'(gnt1), 32'(!exp_g0));
            end
            if (k >= 2) begin
                exp_v0 = ((k - 2) % 2 == 0);
                check("cont_rv0", 32'(rvalid0), 32'(exp_v0));
                check("cont_rv1", 32'(rvalid1), 32'(!exp_v0));
                check("cont_rdata", rdata, exp_v0 ? DATA_A : DATA_B);
            end
            step();
        end

        // Out-of-range write then read from requester 1
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'd24; wdata1 = 32'h5555_AAAA;
        #1;
        check("oor_wr_gnt1", 32'(gnt1), 32'd1);
        step();
        we1 = 1'b0; addr1 = 5'd31;
        #1;
        check("oor_rd_gnt1", 32'(gnt1), 32'd1);
        check("oor_wr_err1", 32'(err1), 32'd1);
        check("oor_wr_err0", 32'(err0), 32'd0);
        check("oor_wr_pins", 32'({sram_cen, sram_wen}), 32'd3);
        step();
        req1 = 1'b0;
        #1;
        check("oor_rd_err1", 32'(err1), 32'd1);
        check("oor_rd_pins", 32'({sram_cen, sram_wen}), 32'd3);
        check("oor_a_hold", 32'(sram_a), 32'd2);
        step();
        check("oor_err1_end", 32'(err1), 32'd0);
        check("oor_rv1_a", 32'(rvalid1), 32'd0);
        step();
        check("oor_rv1_b", 32'(rvalid1), 32'd0);

        // Write then read of the same address on consecutive cycles
        req0 = 1'b1; we0 = 1'b1; addr0 = 5'd3; wdata0 = 32'h0000_0011;
        #1;
        check("haz_wr_gnt0", 32'(gnt0), 32'd1);
        step();
        we0 = 1'b0;
        #1;
        check("haz_rd_gnt0", 32'(gnt0), 32'd1);
        check("haz_wr_a", 32'(sram_a), 32'd3);
        step();
        req0 = 1'b0;
        #1;
        check("haz_rd_cen", 32'(sram_cen), 32'd0);
        step();
        check("haz_rv0", 32'(rvalid0), 32'd1);
        check("haz_rdata", rdata, 32'h0000_0011);

        // Reset arriving while a read is in flight
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5;
        #1;
        check("mid_gnt0", 32'(gnt0), 32'd1);
        step();
        req0 = 1'b0; rstn = 1'b0;
        #1;
        check("mid_cen", 32'(sram_cen), 32'd0);
        step();
        check("mid_rv", 32'({rvalid1, rvalid0, err1, err0}), 32'd0);
        check("mid_pins", 32'({sram_cen, sram_wen}), 32'd3);
        check("mid_a", 32'(sram_a), 32'd0);
        check("mid_d", sram_d, 32'd0);
        rstn = 1'b1; req0 = 1'b1; req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
        #1;
        check("mid_last_gnt0", 32'(gnt0), 32'd1);
        check("mid_last_gnt1", 32'(gnt1), 32'd0);
        step();
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
